// File: rtl/contador_pkg.sv
`default_nettype none
// ============================================================================
// Module      : contador_pkg
// Description : Shared definitions for the up/down modulo counter family.
//               Holds the count-direction encoding and the parameter
//               legality helpers that the counter modules evaluate at
//               elaboration time.
// Revision    : 1.0 - initial release
// ============================================================================
package contador_pkg;

  // Count direction encoding, as seen on the dir input
  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Counter must be at least one bit wide
  function automatic bit width_ok(input int width);
    return (width >= 1);
  endfunction

  // MODULO must lie in 2 .. 2^WIDTH so that MODULO-1 fits in WIDTH bits
  function automatic bit modulo_ok(input int width, input int modulo);
    longint unsigned span;
    span = 64'd1 << width;
    return (modulo >= 2) && (longint'(modulo) <= longint'(span));
  endfunction

  // At least one enabled cycle per count step
  function automatic bit presc_ok(input int presc);
    return (presc >= 1);
  endfunction

  // Prescaler counter width: clog2(PRESC), never below one bit
  function automatic int presc_width(input int presc);
    return (presc > 1) ? $clog2(presc) : 1;
  endfunction

endpackage : contador_pkg
`default_nettype wire

// File: rtl/contador_presc.sv
`default_nettype none
// ============================================================================
// Module      : contador_presc
// Description : Clock-enable prescaler. Counts ce-high cycles 0..PRESC-1 and
//               raises tick (combinationally) on the ce-high cycle where the
//               count sits at PRESC-1; the count then returns to 0.
//               For PRESC = 1 the count is pinned at 0 and tick == ce.
// Ports       : clk   - system clock, rising edge
//               reset - synchronous, active-low reset (clears the count)
//               clr   - synchronous clear (restarts the prescale phase)
//               ce    - count enable
//               tick  - step strobe for the counter
// Revision    : 1.0 - initial release
// ============================================================================
module contador_presc
  import contador_pkg::*;
#(
  parameter int PRESC = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic ce,
  output logic tick
);

  localparam int CW = presc_width(PRESC);
  localparam logic [CW-1:0] c_last = CW'(PRESC - 1);

  generate
    if (!presc_ok(PRESC)) begin : g_bad_presc
      $error("contador_presc: PRESC must be >= 1");
    end
  endgenerate

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          w_at_last;

  assign w_at_last = (cnt_q == c_last);
  assign tick      = ce && w_at_last;

  always_comb begin
    cnt_d = cnt_q;
    if (ce) begin
      if (w_at_last) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : contador_presc
`default_nettype wire

// File: rtl/contador_updown_mod.sv
`default_nettype none
// ============================================================================
// Module      : contador_updown_mod
// Description : Parametrised up/down modulo counter with synchronous load
//               (clamped to MODULO-1), clock-enable prescaler, terminal
//               count flag and a registered one-cycle overflow pulse.
//               Optional saturating mode is compiled in with the macro
//               CONTADOR_SAT_EN; without it the counter always wraps.
// Ports       : clk    - system clock, rising edge
//               reset  - synchronous, active-low reset
//               load   - synchronous load of datain (wins over ce)
//               ce     - count enable, feeds the prescaler
//               dir    - 0 = up, 1 = down
//               sat    - 1 = saturate, 0 = wrap (CONTADOR_SAT_EN only)
//               datain - load value
//               cuenta - current count, registered
//               tc     - terminal count, combinational from cuenta and dir
//               ovf    - registered pulse on a wrap or saturation hit
// Revision    : 1.0 - initial release
// ============================================================================
module contador_updown_mod
  import contador_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int MODULO = 16,
  parameter int PRESC  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             ce,
  input  logic             dir,
`ifdef CONTADOR_SAT_EN
  input  logic             sat,
`endif
  input  logic [WIDTH-1:0] datain,
  output logic [WIDTH-1:0] cuenta,
  output logic             tc,
  output logic             ovf
);

  generate
    if (!width_ok(WIDTH)) begin : g_bad_width
      $error("contador_updown_mod: WIDTH must be >= 1");
    end
    if (!modulo_ok(WIDTH, MODULO)) begin : g_bad_modulo
      $error("contador_updown_mod: MODULO must be in 2..2^WIDTH");
    end
    if (!presc_ok(PRESC)) begin : g_bad_presc
      $error("contador_updown_mod: PRESC must be >= 1");
    end
  endgenerate

  // Top of range, kept one bit wider so MODULO = 2^WIDTH is still exact
  localparam logic [WIDTH:0]   c_max   = (WIDTH + 1)'(MODULO - 1);
  localparam logic [WIDTH-1:0] c_max_n = c_max[WIDTH-1:0];

  logic [WIDTH-1:0] cuenta_q;
  logic [WIDTH-1:0] cuenta_d;
  logic             ovf_q;
  logic             ovf_d;

  logic             w_tick;
  logic             w_sat;
  logic [WIDTH:0]   w_ext;
  logic [WIDTH:0]   w_inc;
  logic [WIDTH:0]   w_dec;
  logic [WIDTH:0]   w_load_ext;
  logic             w_at_top;
  logic             w_at_bot;

`ifdef CONTADOR_SAT_EN
  assign w_sat = sat;
`else
  assign w_sat = 1'b0;
`endif

  // Load restarts the prescale phase, so a load+ce cycle never steps
  contador_presc #(
    .PRESC (PRESC)
  ) u_presc (
    .clk   (clk),
    .reset (reset),
    .clr   (load),
    .ce    (ce),
    .tick  (w_tick)
  );

  // Arithmetic in WIDTH+1 bits; the bound checks below keep the result
  // inside 0..MODULO-1 before it is truncated back to WIDTH bits
  assign w_ext      = {1'b0, cuenta_q};
  assign w_inc      = w_ext + (WIDTH + 1)'(1);
  assign w_dec      = w_ext - (WIDTH + 1)'(1);
  assign w_load_ext = {1'b0, datain};
  assign w_at_top   = (w_ext == c_max);
  assign w_at_bot   = (cuenta_q == '0);

  always_comb begin
    cuenta_d = cuenta_q;
    ovf_d    = 1'b0;
    if (load) begin
      if (w_load_ext > c_max) begin
        cuenta_d = c_max_n;
      end else begin
        cuenta_d = datain;
      end
    end else if (w_tick) begin
      if (dir == DIR_UP) begin
        if (w_at_top) begin
          ovf_d    = 1'b1;
          cuenta_d = w_sat ? cuenta_q : '0;
        end else begin
          cuenta_d = w_inc[WIDTH-1:0];
        end
      end else begin
        if (w_at_bot) begin
          ovf_d    = 1'b1;
          cuenta_d = w_sat ? cuenta_q : c_max_n;
        end else begin
          cuenta_d = w_dec[WIDTH-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cuenta_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      cuenta_q <= cuenta_d;
      ovf_q    <= ovf_d;
    end
  end

  assign cuenta = cuenta_q;
  assign ovf    = ovf_q;
  assign tc     = ((dir == DIR_UP)   && (cuenta_q == c_max_n)) ||
                  ((dir == DIR_DOWN) && w_at_bot);

endmodule : contador_updown_mod
`default_nettype wire

// File: tb/tb_contador_updown_mod.sv
`default_nettype none
// ============================================================================
// Module      : tb_contador_updown_mod
// Description : Self-checking bench for contador_updown_mod. Two instances
//               (PRESC = 1 and PRESC = 3, MODULO = 10) share the stimulus;
//               a behavioural model of each is advanced every clock and
//               compared against cuenta, ovf and tc after each edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_contador_updown_mod;

  localparam int W   = 4;
  localparam int MOD = 10;

  logic         clk = 1'b0;
  logic         reset, load, ce, dir, sat;
  logic [W-1:0] datain;
  logic [W-1:0] cuenta1, cuenta3;
  logic         tc1, tc3, ovf1, ovf3;

  int n_cmp = 0;
  int n_err = 0;

  // Model state per instance: index 0 -> PRESC 1, index 1 -> PRESC 3
  int presc_of [2] = '{1, 3};
  int m_cnt    [2];
  int m_pc     [2];
  int m_ovf    [2];

  always #5 clk = ~clk;

  contador_updown_mod #(.WIDTH(W), .MODULO(MOD), .PRESC(1)) dut1 (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .ce     (ce),
    .dir    (dir),
`ifdef CONTADOR_SAT_EN
    .sat    (sat),
`endif
    .datain (datain),
    .cuenta (cuenta1),
    .tc     (tc1),
    .ovf    (ovf1)
  );

  contador_updown_mod #(.WIDTH(W), .MODULO(MOD), .PRESC(3)) dut3 (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .ce     (ce),
    .dir    (dir),
`ifdef CONTADOR_SAT_EN
    .sat    (sat),
`endif
    .datain (datain),
    .cuenta (cuenta3),
    .tc     (tc3),
    .ovf    (ovf3)
  );

  function automatic bit sat_eff();
`ifdef CONTADOR_SAT_EN
    return sat;
`else
    return 1'b0;
`endif
  endfunction

  // One clock edge of the reference behaviour, from the counting rules
  task automatic model_edge(input int k);
    int step;
    step = 0;
    if (!reset) begin
      m_cnt[k] = 0; m_pc[k] = 0; m_ovf[k] = 0;
    end else if (load) begin
      m_cnt[k] = (int'(datain) > MOD - 1) ? MOD - 1 : int'(datain);
      m_pc[k]  = 0; m_ovf[k] = 0;
    end else if (ce) begin
      if (m_pc[k] == presc_of[k] - 1) begin
        m_pc[k] = 0; step = 1;
      end else begin
        m_pc[k] = m_pc[k] + 1;
      end
      m_ovf[k] = 0;
      if (step != 0) begin
        if (!dir) begin
          m_ovf[k] = (m_cnt[k] == MOD - 1) ? 1 : 0;
          if (!(m_ovf[k] != 0 && sat_eff())) m_cnt[k] = (m_cnt[k] + 1) % MOD;
        end else begin
          m_ovf[k] = (m_cnt[k] == 0) ? 1 : 0;
          if (!(m_ovf[k] != 0 && sat_eff())) m_cnt[k] = (m_cnt[k] + MOD - 1) % MOD;
        end
      end
    end else begin
      m_ovf[k] = 0;
    end
  endtask

  function automatic int model_tc(input int k);
    return dir ? int'(m_cnt[k] == 0) : int'(m_cnt[k] == MOD - 1);
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one edge, update both models, compare all outputs
  task automatic tick();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    chk("cuenta_p1", int'(cuenta1), m_cnt[0]);
    chk("ovf_p1",    int'(ovf1),    m_ovf[0]);
    chk("tc_p1",     int'(tc1),     model_tc(0));
    chk("cuenta_p3", int'(cuenta3), m_cnt[1]);
    chk("ovf_p3",    int'(ovf3),    m_ovf[1]);
    chk("tc_p3",     int'(tc3),     model_tc(1));
  endtask

  task automatic set_in(input logic r, input logic l, input logic c,
                        input logic d, input logic [W-1:0] di);
    reset = r; load = l; ce = c; dir = d; datain = di;
  endtask

  initial begin
    sat = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0; m_pc[k] = 0; m_ovf[k] = 0;
    end

    // 1. reset and clamped load
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    repeat (3) tick();
    chk("reset_cuenta", int'(cuenta1), 0);
    chk("reset_tc",     int'(tc1),     0);
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 4'd13);
    tick();
    chk("clamp_cuenta", int'(cuenta1), 9);
    chk("clamp_tc",     int'(tc1),     1);

    // 2. wrap up: 20 steps return to 9
    set_in(1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
    tick();
    chk("wrapup_zero", int'(cuenta1), 0);
    chk("wrapup_ovf",  int'(ovf1),    1);
    tick();
    chk("wrapup_ovf_drop", int'(ovf1), 0);
    repeat (18) tick();
    chk("wrapup_20", int'(cuenta1), 9);

    // 3. wrap down from 2
    set_in(1'b1, 1'b1, 1'b0, 1'b1, 4'd2);
    tick();
    set_in(1'b1, 1'b0, 1'b1, 1'b1, 4'd0);
    tick();
    tick();
    chk("down_zero_tc", int'(tc1), 1);
    tick();
    chk("down_wrap",     int'(cuenta1), 9);
    chk("down_wrap_ovf", int'(ovf1),    1);
    tick();
    chk("down_eight", int'(cuenta1), 8);

    // 4. prescaler 3, with ce gap mid-prescale
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    tick();
    set_in(1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
    repeat (9) tick();
    chk("presc_9", int'(cuenta3), 3);
    tick();
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    repeat (5) tick();
    chk("presc_hold", int'(cuenta3), 3);
    set_in(1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
    tick();
    chk("presc_phase_a", int'(cuenta3), 3);
    tick();
    chk("presc_phase_b", int'(cuenta3), 4);

`ifdef CONTADOR_SAT_EN
    // 5. saturation
    sat = 1'b1;
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 4'd9);
    tick();
    set_in(1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
    repeat (4) begin
      tick();
      chk("sat_hold", int'(cuenta1), 9);
      chk("sat_ovf",  int'(ovf1),    1);
    end
    dir = 1'b1;
    tick();
    chk("sat_down", int'(cuenta1), 8);
    chk("sat_down_ovf", int'(ovf1), 0);
    tick();
    sat = 1'b0;
`endif

    // 6. priority
    set_in(1'b0, 1'b1, 1'b1, 1'b0, 4'd7);
    tick();
    chk("prio_reset", int'(cuenta1), 0);
    set_in(1'b1, 1'b1, 1'b1, 1'b0, 4'd5);
    tick();
    chk("prio_load_p1", int'(cuenta1), 5);
    chk("prio_load_p3", int'(cuenta3), 5);
    set_in(1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
    tick();
    tick();
    chk("prio_restart", int'(cuenta3), 5);
    tick();
    chk("prio_first_step", int'(cuenta3), 6);

    // Randomised traffic against the model
    for (int i = 0; i < 600; i++) begin
      reset  = ($urandom_range(0, 59) != 0);
      load   = ($urandom_range(0, 11) == 0);
      ce     = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) dir = ~dir;
      datain = W'($urandom_range(0, 15));
      sat    = ($urandom_range(0, 2) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_contador_updown_mod
`default_nettype wire

// File: doc/contador_updown_mod.md
# contador_updown_mod

Parametrised up/down modulo counter with synchronous load, clock-enable prescaler, terminal-count flag and overflow pulse. It succeeds the fixed 4-bit up/down counter in the lab designs. It adds generic width, arbitrary modulus, a ce prescaler and an optional saturating mode. It sits anywhere a timebase, digit counter or event counter is needed, driven by the single system clock.

## Interface
Parameters:
- WIDTH, 4, counter width in bits (>= 1)
- MODULO, 16, count range 0..MODULO-1; legal 2..2^WIDTH
- PRESC, 1, enabled cycles per count step; 1 = step on every ce cycle

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low reset
- load  in  1  synchronous load of datain
- ce  in  1  count enable (feeds prescaler)
- dir  in  1  0 = count up, 1 = count down
- sat  in  1  1 = saturate at bounds, 0 = wrap (present only with CONTADOR_SAT_EN)
- datain  in  WIDTH  load value
- cuenta  out  WIDTH  current count, registered
- tc  out  1  terminal count flag, combinational from cuenta and dir
- ovf  out  1  one-cycle registered pulse on wrap or saturation hit

## Operation
- Priority per clock edge: reset low > load > prescaled step > hold.
- Reset (reset = 0 at edge): cuenta = 0, ovf = 0, prescaler count = 0.
- Load: cuenta = datain if datain <= MODULO-1, else MODULO-1 (clamped). Prescaler cleared, ovf = 0. ce is ignored that cycle.
- Prescaler: counts ce-high cycles 0..PRESC-1. A step occurs on the ce-high edge where the prescaler count = PRESC-1, and the prescaler then returns to 0. With ce low, the prescaler and cuenta hold. A change of dir does not clear the prescaler.
- Step up (dir = 0): cuenta+1.
  - At MODULO-1 in wrap mode: cuenta -> 0, ovf = 1.
  - At MODULO-1 in sat mode: cuenta holds, ovf = 1.
- Step down (dir = 1): cuenta-1.
  - At 0 in wrap mode: cuenta -> MODULO-1, ovf = 1.
  - At 0 in sat mode: cuenta holds, ovf = 1.
- ovf is 0 on every edge without a boundary step.
- tc = (dir = 0 and cuenta = MODULO-1) or (dir = 1 and cuenta = 0). It is independent of ce and sat.
- Arithmetic is done in WIDTH+1 bits internally. No out-of-range value ever appears on cuenta.

## Timing
- cuenta and ovf update one clk edge after the qualifying inputs are sampled.
- tc follows cuenta and dir combinationally in the same cycle.
- Load-to-output latency: 1 cycle. Reset-to-output latency: 1 cycle (synchronous).
- Step rate: one step per PRESC ce-high cycles. First step after reset or load occurs on the PRESC-th ce-high edge.
- load and reset asserted together: reset wins. load and ce together: load wins and the prescaler restarts.
- Reset mid-prescale: the prescaler is cleared and the partial count is discarded.

## Configuration
- CONTADOR_SAT_EN defined:
  - sat port exists.
  - sat = 1 selects saturating bounds; sat = 0 selects wrap.
  - sat is sampled each step.
- CONTADOR_SAT_EN undefined:
  - No sat port.
  - Behaviour is identical to sat = 0 (always wrap).

## Structure
- Shared package contador_pkg holds:
  - DIR_UP = 1'b0 and DIR_DOWN = 1'b1.
  - Parameter-legality checks (MODULO range, PRESC >= 1), raised as elaboration errors.
- One sub-module, contador_presc:
  - Parameter PRESC.
  - Ports clk, reset, clr, ce, tick.
  - Internal counter width clog2(PRESC), minimum 1.
  - tick is combinational: ce and count = PRESC-1.
  - For PRESC = 1 it reduces to tick = ce.
- Top level holds the count register, boundary logic, clamp, tc and the ovf register.

## Test plan
1. Reset and clamped load, WIDTH=4, MODULO=10, PRESC=1:
   - Hold reset = 0 for 3 cycles -> cuenta = 0, ovf = 0, tc = 0 (dir = 0).
   - load with datain = 13 -> cuenta = 9 next cycle, tc = 1.
2. Wrap up: from 9, dir = 0, ce = 1 -> cuenta 0 with ovf high exactly 1 cycle, then 1, 2, …; 20 steps return cuenta to 9.
3. Wrap down: load 2, dir = 1, ce = 1 -> 1, 0, 9 (ovf pulse on that edge), 8; tc = 1 while cuenta = 0.
4. Prescaler, PRESC=3:
   - ce = 1 for 9 cycles from 0 up -> cuenta = 1, 2, 3 at cycles 3, 6, 9.
   - Drop ce for 5 cycles mid-prescale -> no change, phase preserved.
5. Saturation (CONTADOR_SAT_EN, sat = 1):
   - Load 9, dir = 0, ce = 1 for 4 cycles -> cuenta stays 9, ovf = 1 each cycle.
   - Switch dir = 1 -> 8, 7 with ovf = 0.
6. Priority: reset = 0, load = 1, ce = 1 together -> cuenta = 0. Then load = 1 with ce = 1 and datain = 5 -> cuenta = 5, no step, prescaler restarted.
